// File: rtl/cga_vram_arbiter_pkg.sv
// Shared definitions for the CGA VRAM arbiter: FSM state encoding and default address width.
package cga_vram_arbiter_pkg;

    localparam int ADDR_W_DEF = 15;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_DONE   = 3'd4
    } arb_state_e;

    // True while an ISA transaction is driving the SRAM control sequence.
    function automatic logic in_xfer(input arb_state_e st);
        return (st == ST_SETUP) || (st == ST_STROBE) || (st == ST_HOLD);
    endfunction

endpackage

// File: rtl/cga_vram_post_buf.sv
// One-entry posted-write buffer (address, data, valid) used when ISA_WRITE_POST_EN is defined.
`ifdef ISA_WRITE_POST_EN
module cga_vram_post_buf #(
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic              clear,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [7:0]        data_in,
    output logic              valid,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        data
);

    logic              valid_r;
    logic [ADDR_W-1:0] addr_r;
    logic [7:0]        data_r;

    // Buffer entry; load and clear are never requested in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_r <= 1'b0;
            addr_r  <= {ADDR_W{1'b0}};
            data_r  <= 8'h00;
        end else if (load) begin
            valid_r <= 1'b1;
            addr_r  <= addr_in;
            data_r  <= data_in;
        end else if (clear) begin
            valid_r <= 1'b0;
        end
    end

    assign valid = valid_r;
    assign addr  = addr_r;
    assign data  = data_r;

endmodule
`endif

// File: rtl/cga_vram_arbiter.sv
// Shares the single 8-bit VRAM SRAM between CRTC display fetch and ISA CPU accesses.
// Define ISA_WRITE_POST_EN to post ISA writes through a one-entry buffer.
module cga_vram_arbiter
    import cga_vram_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              vram_read,
    input  logic              vram_read_a0,
    input  logic              isa_op_enable,
    input  logic [ADDR_W-2:0] disp_addr,
    input  logic              isa_req,
    input  logic              isa_we,
    input  logic [ADDR_W-1:0] isa_addr,
    input  logic [7:0]        isa_wdata,
    output logic              isa_ack,
    output logic [7:0]        isa_rdata,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_oe_l,
    output logic              ram_we_l,
    output logic [7:0]        ram_d_out,
    output logic              ram_d_oe,
    input  logic [7:0]        ram_d_in,
    output logic              arb_busy,
    output logic              arb_collision
);

    arb_state_e        state_r;
    arb_state_e        state_s;
    logic              start_s;
    logic              slot_free_s;
    logic [ADDR_W-1:0] addr_q_r;
    logic              we_q_r;
    logic [7:0]        wdata_q_r;
    logic [7:0]        rdata_r;
    logic              collision_r;

    assign slot_free_s = isa_op_enable & ~vram_read;

`ifdef ISA_WRITE_POST_EN
    logic              drain_s;
    logic              post_load_s;
    logic              drain_r;
    logic              buf_valid_s;
    logic [ADDR_W-1:0] buf_addr_s;
    logic [7:0]        buf_data_s;

    cga_vram_post_buf #(
        .ADDR_W (ADDR_W)
    ) u_post_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (post_load_s),
        .clear   (drain_s),
        .addr_in (isa_addr),
        .data_in (isa_wdata),
        .valid   (buf_valid_s),
        .addr    (buf_addr_s),
        .data    (buf_data_s)
    );
`endif

    // Next-state logic; a pending posted write drains before any other request is served.
    always_comb begin
        state_s = state_r;
        start_s = 1'b0;
`ifdef ISA_WRITE_POST_EN
        drain_s     = 1'b0;
        post_load_s = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
`ifdef ISA_WRITE_POST_EN
                if (buf_valid_s) begin
                    if (slot_free_s) begin
                        drain_s = 1'b1;
                        state_s = ST_SETUP;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else if (isa_req && isa_we) begin
                    post_load_s = 1'b1;
                    state_s     = ST_DONE;
                end else if (isa_req && slot_free_s) begin
                    start_s = 1'b1;
                    state_s = ST_SETUP;
                end else begin
                    state_s = ST_IDLE;
                end
`else
                if (isa_req && slot_free_s) begin
                    start_s = 1'b1;
                    state_s = ST_SETUP;
                end else begin
                    state_s = ST_IDLE;
                end
`endif
            end
            ST_SETUP:  state_s = ST_STROBE;
            ST_STROBE: state_s = ST_HOLD;
            ST_HOLD: begin
`ifdef ISA_WRITE_POST_EN
                // A drained posted write was already acknowledged when it was buffered.
                if (drain_r) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
`else
                state_s = ST_DONE;
`endif
            end
            ST_DONE: begin
                if (isa_req) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register, transaction latches, read capture and collision flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            addr_q_r    <= {ADDR_W{1'b0}};
            we_q_r      <= 1'b0;
            wdata_q_r   <= 8'h00;
            rdata_r     <= 8'h00;
            collision_r <= 1'b0;
`ifdef ISA_WRITE_POST_EN
            drain_r     <= 1'b0;
`endif
        end else begin
            state_r     <= state_s;
            collision_r <= vram_read & in_xfer(state_r);
            if (start_s) begin
                addr_q_r  <= isa_addr;
                we_q_r    <= isa_we;
                wdata_q_r <= isa_wdata;
            end
`ifdef ISA_WRITE_POST_EN
            if (drain_s) begin
                addr_q_r  <= buf_addr_s;
                we_q_r    <= 1'b1;
                wdata_q_r <= buf_data_s;
            end
            if (start_s || drain_s) begin
                drain_r <= drain_s;
            end
`endif
            if ((state_r == ST_STROBE) && !we_q_r) begin
                rdata_r <= ram_d_in;
            end
        end
    end

    // Display fetch always wins the address bus and suppresses any ISA write strobe.
    assign ram_a     = vram_read ? {disp_addr, vram_read_a0} : addr_q_r;
    assign ram_oe_l  = ~(vram_read | ((state_r == ST_STROBE) & ~we_q_r));
    assign ram_we_l  = ~((state_r == ST_STROBE) & we_q_r & ~vram_read);
    assign ram_d_oe  = we_q_r & in_xfer(state_r) & ~vram_read;
    assign ram_d_out = wdata_q_r;

    assign isa_ack       = (state_r == ST_DONE);
    assign isa_rdata     = rdata_r;
    assign arb_collision = collision_r;
`ifdef ISA_WRITE_POST_EN
    assign arb_busy = (state_r != ST_IDLE) || buf_valid_s;
`else
    assign arb_busy = (state_r != ST_IDLE);
`endif

endmodule

// File: tb/tb_cga_vram_arbiter.sv
// Randomized self-checking bench for cga_vram_arbiter against a transaction-level memory model.
// Honours ISA_WRITE_POST_EN for the expected write acknowledge latency.
module tb_cga_vram_arbiter;

`ifdef ISA_WRITE_POST_EN
    localparam int WR_LAT = 1;
`else
    localparam int WR_LAT = 4;
`endif
    localparam int PERIOD = 20;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        vram_read, vram_read_a0, isa_op_enable;
    logic [13:0] disp_addr;
    logic        isa_req, isa_we;
    logic [14:0] isa_addr;
    logic [7:0]  isa_wdata;
    logic        isa_ack;
    logic [7:0]  isa_rdata;
    logic [14:0] ram_a;
    logic        ram_oe_l, ram_we_l, ram_d_oe;
    logic [7:0]  ram_d_out, ram_d_in;
    logic        arb_busy, arb_collision;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int phase;
    bit manual_seq;
    int we_low_cnt, coll_cnt;
    logic [14:0] we_low_addr;
    logic [7:0]  we_low_data;

    // SRAM device model and expected contents (transaction-level view).
    logic [7:0] sram [0:32767];
    bit         sram_vld [0:32767];
    logic [7:0] ref_mem [0:32767];

    always #5 clk = ~clk;

    cga_vram_arbiter dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .vram_read     (vram_read),
        .vram_read_a0  (vram_read_a0),
        .isa_op_enable (isa_op_enable),
        .disp_addr     (disp_addr),
        .isa_req       (isa_req),
        .isa_we        (isa_we),
        .isa_addr      (isa_addr),
        .isa_wdata     (isa_wdata),
        .isa_ack       (isa_ack),
        .isa_rdata     (isa_rdata),
        .ram_a         (ram_a),
        .ram_oe_l      (ram_oe_l),
        .ram_we_l      (ram_we_l),
        .ram_d_out     (ram_d_out),
        .ram_d_oe      (ram_d_oe),
        .ram_d_in      (ram_d_in),
        .arb_busy      (arb_busy),
        .arb_collision (arb_collision)
    );

    function automatic logic [7:0] init_pat(input logic [14:0] a);
        return a[7:0] ^ {a[14:8], 1'b1};
    endfunction

    assign ram_d_in = sram_vld[ram_a] ? sram[ram_a] : init_pat(ram_a);

    always @(posedge clk) begin
        if (!ram_we_l) begin
            sram[ram_a]     <= ram_d_out;
            sram_vld[ram_a] <= 1'b1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Advance one cycle and drive the sequencer slots: fetch in phases 0-3, ISA window 4-14.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (!manual_seq) begin
            phase         = cyc % PERIOD;
            vram_read     = (phase < 4);
            isa_op_enable = (phase >= 4) && (phase <= 14);
            disp_addr     = 14'($urandom);
            vram_read_a0  = 1'($urandom);
        end
    endtask

    task automatic sample();
        logic [14:0] exp_a;
        @(negedge clk);
        if (vram_read) begin
            exp_a = {disp_addr, vram_read_a0};
            check_val("disp_ram_a", 32'(ram_a), 32'(exp_a));
            check_val("disp_oe_l", 32'(ram_oe_l), 32'd0);
            check_val("disp_we_l", 32'(ram_we_l), 32'd1);
        end
        if (!ram_we_l) begin
            we_low_cnt++;
            we_low_addr = ram_a;
            we_low_data = ram_d_out;
            check_val("we_d_oe", 32'(ram_d_oe), 32'd1);
        end
        if (arb_collision) coll_cnt++;
    endtask

    task automatic align(input int target);
        while (((cyc + 1) % PERIOD) != target) begin
            tick();
            sample();
        end
    endtask

    task automatic isa_xfer(input logic we, input logic [14:0] a, input logic [7:0] wd,
                            output int lat, output logic [7:0] rd);
        int n;
        tick();
        isa_req = 1'b1; isa_we = we; isa_addr = a; isa_wdata = wd;
        sample();
        lat = 0;
        while (!isa_ack && lat < 200) begin
            tick();
            sample();
            lat++;
        end
        check_val("ack_seen", 32'(isa_ack), 32'd1);
        rd = isa_rdata;
        if (we) ref_mem[a] = wd;
        else    check_val("rdata", 32'(isa_rdata), 32'(ref_mem[a]));
        tick();
        isa_req = 1'b0; isa_we = 1'($urandom); isa_addr = 15'($urandom); isa_wdata = 8'($urandom);
        sample();
        n = 0;
        while (isa_ack && n < 10) begin
            tick();
            sample();
            n++;
        end
        check_val("ack_drop", 32'(isa_ack), 32'd0);
    endtask

    initial begin
        int lat, n;
        logic [7:0]  rd;
        logic [14:0] pool [6];
        logic [14:0] a;
        logic        we;

        for (int i = 0; i < 32768; i++) ref_mem[i] = init_pat(15'(i));
        for (int i = 0; i < 6; i++) pool[i] = 15'($urandom);
        reset_n = 1'b0; manual_seq = 1'b1;
        vram_read = 1'b0; vram_read_a0 = 1'b0; isa_op_enable = 1'b0; disp_addr = 14'h0000;
        isa_req = 1'b0; isa_we = 1'b0; isa_addr = 15'h0000; isa_wdata = 8'h00;
        we_low_cnt = 0; coll_cnt = 0;

        // Reset values
        tick();
        sample();
        check_val("rst_ack", 32'(isa_ack), 32'd0);
        check_val("rst_rdata", 32'(isa_rdata), 32'd0);
        check_val("rst_we_l", 32'(ram_we_l), 32'd1);
        check_val("rst_oe_l", 32'(ram_oe_l), 32'd1);
        check_val("rst_d_oe", 32'(ram_d_oe), 32'd0);
        check_val("rst_busy", 32'(arb_busy), 32'd0);
        check_val("rst_coll", 32'(arb_collision), 32'd0);
        tick();
        reset_n = 1'b1; manual_seq = 1'b0;
        sample();

        // Async reset in the middle of a write strobe
        align(4);
        tick();
        isa_req = 1'b1; isa_we = 1'b1; isa_addr = 15'h0456; isa_wdata = 8'h3C;
        sample();
        n = 0;
        while (ram_we_l && n < 60) begin
            tick();
            if (isa_ack) isa_req = 1'b0;
            sample();
            n++;
        end
        check_val("rst_strobe_reached", 32'(ram_we_l), 32'd0);
        #1 reset_n = 1'b0;
        #1;
        check_val("rst_mid_we_l", 32'(ram_we_l), 32'd1);
        check_val("rst_mid_ack", 32'(isa_ack), 32'd0);
        check_val("rst_mid_busy", 32'(arb_busy), 32'd0);
        isa_req = 1'b0;
        tick();
        sample();
        tick();
        reset_n = 1'b1;
        sample();
        isa_xfer(1'b0, 15'h0456, 8'h00, lat, rd);

        // Write at window start: exactly one strobe cycle at the latched address
        align(4);
        we_low_cnt = 0;
        isa_xfer(1'b1, 15'h0123, 8'hA5, lat, rd);
        check_val("wr_lat", 32'(lat), 32'(WR_LAT));
        for (int i = 0; i < 25; i++) begin
            tick();
            sample();
        end
        check_val("wr_strobe_cnt", 32'(we_low_cnt), 32'd1);
        check_val("wr_strobe_addr", 32'(we_low_addr), 32'h0123);
        check_val("wr_strobe_data", 32'(we_low_data), 32'hA5);

        // Read at the top address
        isa_xfer(1'b1, 15'h7FFF, 8'h5A, lat, rd);
        align(4);
        isa_xfer(1'b0, 15'h7FFF, 8'h00, lat, rd);
        check_val("rd_7fff", 32'(rd), 32'h5A);
        check_val("rd_lat", 32'(lat), 32'd4);

        // Window edges: last window cycle still starts, first cycle after it waits
        align(14);
        coll_cnt = 0;
        isa_xfer(1'b0, 15'h0123, 8'h00, lat, rd);
        check_val("edge14_lat", 32'(lat), 32'd4);
        check_val("edge14_coll", 32'(coll_cnt), 32'd0);
        align(15);
        isa_xfer(1'b0, 15'h0124, 8'h00, lat, rd);
        check_val("edge15_lat", 32'(lat), 32'd13);

        // Display fetch owns the bus and holds off an ISA read
        tick();
        manual_seq = 1'b1; vram_read = 1'b1; isa_op_enable = 1'b1;
        disp_addr = 14'h1000; vram_read_a0 = 1'b1;
        isa_req = 1'b1; isa_we = 1'b0; isa_addr = 15'h0042;
        sample();
        check_val("disp_a_2001", 32'(ram_a), 32'h2001);
        tick();
        sample();
        check_val("disp_holdoff1", 32'(arb_busy), 32'd0);
        tick();
        vram_read = 1'b0;
        sample();
        check_val("disp_holdoff2", 32'(arb_busy), 32'd0);
        tick();
        sample();
        check_val("disp_release", 32'(arb_busy), 32'd1);
        n = 0;
        while (!isa_ack && n < 10) begin
            tick();
            sample();
            n++;
        end
        check_val("disp_rd_ack", 32'(isa_ack), 32'd1);
        check_val("disp_rd_data", 32'(isa_rdata), 32'(ref_mem[15'h0042]));
        tick();
        isa_req = 1'b0; isa_op_enable = 1'b0;
        sample();
        tick();
        sample();

        // Collision: fetch slot during STROBE of a read
        tick();
        vram_read = 1'b0; isa_op_enable = 1'b1;
        isa_req = 1'b1; isa_we = 1'b0; isa_addr = 15'h0333;
        coll_cnt = 0;
        sample();
        tick();
        isa_op_enable = 1'b0;
        sample();
        tick();
        vram_read = 1'b1;
        sample();
        tick();
        vram_read = 1'b0;
        sample();
        check_val("coll_pulse", 32'(arb_collision), 32'd1);
        tick();
        sample();
        check_val("coll_ack", 32'(isa_ack), 32'd1);
        check_val("coll_pulse_end", 32'(arb_collision), 32'd0);
        check_val("coll_cnt", 32'(coll_cnt), 32'd1);
        tick();
        isa_req = 1'b0;
        sample();
        tick();
        manual_seq = 1'b0;
        sample();
        check_val("coll_ack_drop", 32'(isa_ack), 32'd0);

        // Write immediately followed by a read of the same address
        isa_xfer(1'b1, 15'h0777, 8'hC3, lat, rd);
        check_val("post_wr_lat", 32'(lat), 32'(WR_LAT));
        isa_xfer(1'b0, 15'h0777, 8'h00, lat, rd);
        check_val("post_rd_data", 32'(rd), 32'hC3);

        // Randomized traffic against the memory model
        for (int t = 0; t < 40; t++) begin
            a  = ($urandom_range(9, 0) < 7) ? pool[$urandom_range(5, 0)] : 15'($urandom);
            we = 1'($urandom);
            isa_xfer(we, a, 8'($urandom), lat, rd);
            n = $urandom_range(5, 0);
            for (int i = 0; i < n; i++) begin
                tick();
                sample();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
